// File: rtl/top_bus_master_if.sv
// top_bus_master_if: command/response handshake between a client and the
// multiplexed-bus master.
interface top_bus_master_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic [7:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;

   modport master (
      output cmd_valid,
      output cmd_write,
      output cmd_addr,
      output cmd_wdata,
      input  cmd_ready,
      input  rsp_valid,
      input  rsp_rdata
   );

   modport slave (
      input  cmd_valid,
      input  cmd_write,
      input  cmd_addr,
      input  cmd_wdata,
      output cmd_ready,
      output rsp_valid,
      output rsp_rdata
   );
endinterface

// File: rtl/top_bus_master.sv
// top_bus_master: one-command-at-a-time master for a multiplexed 8-bit
// address/data bus with ALE and active-low read/write strobes.
module top_bus_master #(
   parameter int PULSE = 2,
   parameter int HOLD  = 1
) (
   input  logic            clk,
   input  logic            rst,
   top_bus_master_if.slave cmd,
   inout  wire  [7:0]      bus_data,
   output logic            bus_ale,
   output logic            bus_write,
   output logic            bus_read
);

   typedef enum logic [2:0] {
      IDLE,
      ALE_ACT,
      ALE_HOLD,
      WR_ACT,
      WR_HOLD,
      RD_ACT,
      RD_RECOV
   } state_t;

   localparam logic [7:0] P_LD = 8'(PULSE - 1);
   localparam logic [7:0] H_LD = 8'(HOLD - 1);

   state_t     state;
   logic [7:0] cnt;
   logic       is_write;
   logic [7:0] wdata;
   logic       data_oe;
   logic [7:0] data_out;
   logic       done;

   assign done     = (cnt == 8'd0);
   assign bus_data = data_oe ? data_out : 8'hzz;

   // Every strobe change lands on the same edge as the state change, and the
   // data driver is released on the edge that drops bus_read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= 8'd0;
         is_write      <= 1'b0;
         wdata         <= 8'h00;
         data_oe       <= 1'b0;
         data_out      <= 8'h00;
         bus_ale       <= 1'b0;
         bus_write     <= 1'b1;
         bus_read      <= 1'b1;
         cmd.cmd_ready <= 1'b0;
         cmd.rsp_valid <= 1'b0;
         cmd.rsp_rdata <= 8'h00;
      end else begin
         cmd.rsp_valid <= 1'b0;
         if (state != IDLE) begin
            cnt <= cnt - 8'd1;
         end
         case (state)
            IDLE: begin
               cmd.cmd_ready <= 1'b1;
               if (cmd.cmd_valid && cmd.cmd_ready) begin
                  state         <= ALE_ACT;
                  cnt           <= P_LD;
                  is_write      <= cmd.cmd_write;
                  wdata         <= cmd.cmd_wdata;
                  data_out      <= cmd.cmd_addr;
                  data_oe       <= 1'b1;
                  bus_ale       <= 1'b1;
                  cmd.cmd_ready <= 1'b0;
               end
            end
            ALE_ACT: begin
               if (done) begin
                  state   <= ALE_HOLD;
                  cnt     <= H_LD;
                  bus_ale <= 1'b0;
               end
            end
            ALE_HOLD: begin
               if (done) begin
                  cnt <= P_LD;
                  if (is_write) begin
                     state     <= WR_ACT;
                     data_out  <= wdata;
                     bus_write <= 1'b0;
                  end else begin
                     state    <= RD_ACT;
                     data_oe  <= 1'b0;
                     bus_read <= 1'b0;
                  end
               end
            end
            WR_ACT: begin
               if (done) begin
                  state     <= WR_HOLD;
                  cnt       <= H_LD;
                  bus_write <= 1'b1;
               end
            end
            WR_HOLD: begin
               if (done) begin
                  state         <= IDLE;
                  cnt           <= 8'd0;
                  data_oe       <= 1'b0;
                  cmd.cmd_ready <= 1'b1;
               end
            end
            RD_ACT: begin
               if (done) begin
                  state         <= RD_RECOV;
                  cnt           <= H_LD;
                  bus_read      <= 1'b1;
                  cmd.rsp_rdata <= bus_data;
               end
            end
            RD_RECOV: begin
               if (done) begin
                  state         <= IDLE;
                  cnt           <= 8'd0;
                  cmd.cmd_ready <= 1'b1;
                  cmd.rsp_valid <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               cnt       <= 8'd0;
               data_oe   <= 1'b0;
               bus_ale   <= 1'b0;
               bus_write <= 1'b1;
               bus_read  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_top_bus_master.sv
// tb_top_bus_master: table vectors, random commands and reset corner cases
// checked against a phase-timing model of the bus cycle.
module tb_top_bus_master;

   localparam int P0 = 2;
   localparam int H0 = 1;
   localparam int P1 = 1;
   localparam int H1 = 1;
   localparam int P2 = 5;
   localparam int H2 = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   logic [7:0] last = 8'h00;

   always #5 clk = ~clk;

   top_bus_master_if i0 ();
   top_bus_master_if i1 ();
   top_bus_master_if i2 ();

   wire  [7:0] bus0, bus1, bus2;
   logic       ale0, wr0, rd0, ale1, wr1, rd1, ale2, wr2, rd2;
   logic [7:0] rv0 = 8'h00;
   logic [7:0] rv1 = 8'h00;
   logic [7:0] rv2 = 8'h00;

   assign bus0 = !rd0 ? rv0 : 8'hzz;
   assign bus1 = !rd1 ? rv1 : 8'hzz;
   assign bus2 = !rd2 ? rv2 : 8'hzz;

   top_bus_master #(.PULSE(P0), .HOLD(H0)) dut0 (
      .clk(clk), .rst(rst), .cmd(i0.slave), .bus_data(bus0),
      .bus_ale(ale0), .bus_write(wr0), .bus_read(rd0));
   top_bus_master #(.PULSE(P1), .HOLD(H1)) dut1 (
      .clk(clk), .rst(rst), .cmd(i1.slave), .bus_data(bus1),
      .bus_ale(ale1), .bus_write(wr1), .bus_read(rd1));
   top_bus_master #(.PULSE(P2), .HOLD(H2)) dut2 (
      .clk(clk), .rst(rst), .cmd(i2.slave), .bus_data(bus2),
      .bus_ale(ale2), .bus_write(wr2), .bus_read(rd2));

   typedef struct {
      bit         w;
      logic [7:0] a;
      logic [7:0] d;
      logic [7:0] rv;
      bit         junk;
      bit         exp_rsp;
      logic [7:0] exp_rdata;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Cycle k after the accepting edge: 0 = ALE, 1 = ALE hold,
   // 2 = strobe active, 3 = hold/recovery.
   function automatic int phase(int k, int p, int h);
      if (k < p) return 0;
      if (k < p + h) return 1;
      if (k < 2 * p + h) return 2;
      return 3;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         chk("one_strobe0", int'($countones({ale0, !wr0, !rd0}) <= 1), 1);
         chk("one_strobe1", int'($countones({ale1, !wr1, !rd1}) <= 1), 1);
         chk("one_strobe2", int'($countones({ale2, !wr2, !rd2}) <= 1), 1);
         chk("drive_in_rd0", int'(dut0.data_oe && !rd0), 0);
         chk("drive_in_rd1", int'(dut1.data_oe && !rd1), 0);
         chk("drive_in_rd2", int'(dut2.data_oe && !rd2), 0);
      end
   end

   // Called at a negedge; returns at the negedge of the first idle cycle.
   task automatic do_cmd(input bit w, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] rv, input bit junk);
      int n;
      int ph;
      bit e_ale, e_wr, e_rd, e_oe;
      logic [7:0] e_dat;
      n = 0;
      while (!i0.cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", int'(i0.cmd_ready), 1);
      i0.cmd_valid = 1'b1;
      i0.cmd_write = w;
      i0.cmd_addr  = a;
      i0.cmd_wdata = d;
      rv0 = rv;
      @(negedge clk);
      for (int k = 0; k < 2 * (P0 + H0); k++) begin
         ph = phase(k, P0, H0);
         e_ale = (ph == 0);
         e_wr  = !(ph == 2 && w);
         e_rd  = !(ph == 2 && !w);
         e_oe  = (ph < 2) || w;
         e_dat = (ph < 2) ? a : d;
         chk("busy_ready", int'(i0.cmd_ready), 0);
         chk("busy_rsp", int'(i0.rsp_valid), 0);
         chk("bus_ale", int'(ale0), int'(e_ale));
         chk("bus_write", int'(wr0), int'(e_wr));
         chk("bus_read", int'(rd0), int'(e_rd));
         chk("bus_oe", int'(dut0.data_oe), int'(e_oe));
         if (e_oe) chk("bus_data", int'(bus0), int'(e_dat));
         chk("busy_rdata", int'(i0.rsp_rdata),
             int'((!w && ph == 3) ? rv : last));
         if (junk) begin
            i0.cmd_valid = 1'($urandom_range(0, 1));
            i0.cmd_write = 1'($urandom_range(0, 1));
            i0.cmd_addr  = 8'($urandom);
            i0.cmd_wdata = 8'($urandom);
         end else begin
            i0.cmd_valid = 1'b0;
         end
         @(negedge clk);
      end
      if (!w) last = rv;
      chk("idle_ready", int'(i0.cmd_ready), 1);
      chk("idle_rsp", int'(i0.rsp_valid), int'(!w));
      chk("idle_rdata", int'(i0.rsp_rdata), int'(last));
      chk("idle_ale", int'(ale0), 0);
      chk("idle_write", int'(wr0), 1);
      chk("idle_read", int'(rd0), 1);
      chk("idle_oe", int'(dut0.data_oe), 0);
      i0.cmd_valid = 1'b0;
   endtask

   task automatic busy_count(input int inst, input bit w, output int n);
      n = 0;
      if (inst == 1) begin
         i1.cmd_valid = 1'b1;
         i1.cmd_write = w;
         i1.cmd_addr  = 8'h33;
         i1.cmd_wdata = 8'h44;
      end else begin
         i2.cmd_valid = 1'b1;
         i2.cmd_write = w;
         i2.cmd_addr  = 8'h55;
         i2.cmd_wdata = 8'h66;
      end
      @(negedge clk);
      i1.cmd_valid = 1'b0;
      i2.cmd_valid = 1'b0;
      while (n < 200 && !(inst == 1 ? i1.cmd_ready : i2.cmd_ready)) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      int n;
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      i0.cmd_valid = 1'b0; i0.cmd_write = 1'b0; i0.cmd_addr = 8'h00; i0.cmd_wdata = 8'h00;
      i1.cmd_valid = 1'b0; i1.cmd_write = 1'b0; i1.cmd_addr = 8'h00; i1.cmd_wdata = 8'h00;
      i2.cmd_valid = 1'b0; i2.cmd_write = 1'b0; i2.cmd_addr = 8'h00; i2.cmd_wdata = 8'h00;

      tbl[0] = '{1'b1, 8'h12, 8'h82, 8'h00, 1'b0, 1'b0, 8'h00};
      tbl[1] = '{1'b0, 8'h16, 8'h00, 8'hA5, 1'b0, 1'b1, 8'hA5};
      tbl[2] = '{1'b0, 8'h10, 8'h00, 8'h3C, 1'b0, 1'b1, 8'h3C};
      tbl[3] = '{1'b1, 8'h55, 8'hAA, 8'h00, 1'b0, 1'b0, 8'h3C};
      tbl[4] = '{1'b0, 8'h17, 8'h00, 8'hC3, 1'b0, 1'b1, 8'hC3};
      tbl[5] = '{1'b1, 8'hFF, 8'h00, 8'h11, 1'b1, 1'b0, 8'hC3};
      tbl[6] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00};
      tbl[7] = '{1'b0, 8'h80, 8'h00, 8'h7E, 1'b1, 1'b1, 8'h7E};

      @(negedge clk);
      chk("rst_ready", int'(i0.cmd_ready), 0);
      chk("rst_ale", int'(ale0), 0);
      chk("rst_write", int'(wr0), 1);
      chk("rst_read", int'(rd0), 1);
      chk("rst_oe", int'(dut0.data_oe), 0);
      chk("rst_rsp", int'(i0.rsp_valid), 0);
      chk("rst_rdata", int'(i0.rsp_rdata), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", int'(i0.cmd_ready), 1);

      for (int i = 0; i < 8; i++) begin
         do_cmd(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].rv, tbl[i].junk);
         chk("vec_rsp", int'(i0.rsp_valid), int'(tbl[i].exp_rsp));
         chk("vec_rdata", int'(i0.rsp_rdata), int'(tbl[i].exp_rdata));
      end

      for (int i = 0; i < 40; i++) begin
         do_cmd(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                8'($urandom), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) == 0) begin
            @(negedge clk);
            chk("gap_rsp", int'(i0.rsp_valid), 0);
            chk("gap_ready", int'(i0.cmd_ready), 1);
            chk("gap_rdata", int'(i0.rsp_rdata), int'(last));
         end
      end

      // Reset in the middle of a write strobe.
      i0.cmd_valid = 1'b1; i0.cmd_write = 1'b1;
      i0.cmd_addr = 8'h21; i0.cmd_wdata = 8'h43;
      @(negedge clk);
      i0.cmd_valid = 1'b0;
      repeat (P0 + H0) @(negedge clk);
      chk("wr_act_pre", int'(wr0), 0);
      #2 rst = 1'b1;
      #1;
      chk("abort_wr_write", int'(wr0), 1);
      chk("abort_wr_oe", int'(dut0.data_oe), 0);
      chk("abort_wr_ale", int'(ale0), 0);
      chk("abort_wr_ready", int'(i0.cmd_ready), 0);
      chk("abort_wr_rsp", int'(i0.rsp_valid), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      last = 8'h00;
      @(negedge clk);
      chk("abort_wr_ready_rel", int'(i0.cmd_ready), 1);
      for (int k = 0; k < 6; k++) begin
         chk("abort_wr_quiet_rsp", int'(i0.rsp_valid), 0);
         chk("abort_wr_quiet_wr", int'(wr0), 1);
         chk("abort_wr_quiet_ale", int'(ale0), 0);
         @(negedge clk);
      end

      // Reset in the middle of a read strobe.
      rv0 = 8'h99;
      i0.cmd_valid = 1'b1; i0.cmd_write = 1'b0; i0.cmd_addr = 8'h44;
      @(negedge clk);
      i0.cmd_valid = 1'b0;
      repeat (P0 + H0) @(negedge clk);
      chk("rd_act_pre", int'(rd0), 0);
      #2 rst = 1'b1;
      #1;
      chk("abort_rd_read", int'(rd0), 1);
      chk("abort_rd_oe", int'(dut0.data_oe), 0);
      chk("abort_rd_rdata", int'(i0.rsp_rdata), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_rd_ready_rel", int'(i0.cmd_ready), 1);
      for (int k = 0; k < 8; k++) begin
         chk("abort_rd_quiet_rsp", int'(i0.rsp_valid), 0);
         chk("abort_rd_quiet_rdata", int'(i0.rsp_rdata), 0);
         chk("abort_rd_quiet_rd", int'(rd0), 1);
         @(negedge clk);
      end

      chk("p1_ready_pre", int'(i1.cmd_ready), 1);
      rv1 = 8'h5A;
      busy_count(1, 1'b0, n);
      chk("busy_p1h1_read", n, 2 * (P1 + H1));
      chk("p1_rsp", int'(i1.rsp_valid), 1);
      chk("p1_rdata", int'(i1.rsp_rdata), 8'h5A);

      chk("p5_ready_pre", int'(i2.cmd_ready), 1);
      busy_count(2, 1'b1, n);
      chk("busy_p5h3_write", n, 2 * (P2 + H2));
      chk("p5_rsp", int'(i2.rsp_valid), 0);
      chk("p5_rdata", int'(i2.rsp_rdata), 0);

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
